ysyx_24080014_lsu: RTL and testbench

- Load/store unit: the initiator side of the CPU data-memory port.
- Accepts one load or store from EXU via valid/ready and drives the single-request memory port (valid/wen/ren/wmask/addr/din, returns mem_ready/dout).
- Handles byte/half/word alignment, lane steering, sign/zero extension and error reporting.
- Returns one response per request to WBU.

---
 rtl/ysyx_24080014_lsu.sv | 168 ++++++++++++++++
 tb/tb_ysyx_24080014_lsu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu: load/store unit, initiator side of the data-memory port.
// It accepts one EXU request, issues at most one memory beat, and returns one response.
// Optional macro YSYX_24080014_LSU_TIMEOUT_EN aborts a load that waits TIMEOUT cycles
// in WAIT_R. Without the macro, WAIT_R waits indefinitely for mem_ready.
module ysyx_24080014_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_din,
    input  logic        mem_ready,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    state_t      state, state_nxt;
    logic        wen_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    // Alignment check on the incoming request.
    // Size 11 is illegal, and a misaligned access never reaches memory.
    logic req_bad;
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    logic fire_req, fire_resp, timed_out;
    assign fire_req  = req_valid & req_ready;
    assign fire_resp = resp_valid & resp_ready;

`ifdef YSYX_24080014_LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    assign timed_out = (state == WAIT_R) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));

    // Count WAIT_R cycles that pass without mem_ready. The count restarts on every load issue.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT_R) cnt <= '0;
        else if (!mem_ready)        cnt <= cnt + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT > CNT_W);
    assign timed_out  = 1'b0;
`endif

    // Load lane extraction: shift the addressed lane down, then extend it.
    logic [31:0] lane, load_data;
    always_comb begin
        lane      = mem_dout >> {addr_q[1:0], 3'b000};
        load_data = mem_dout;
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}},  lane[7:0]};
            2'b01:   load_data = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_data = mem_dout;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        mem_wmask  = 8'h00;
        mem_waddr  = 32'h0;
        mem_raddr  = 32'h0;
        mem_din    = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (fire_req) state_nxt = req_bad ? RESP : REQ;
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_ren   = !wen_q;
                mem_waddr = {addr_q[31:2], 2'b00};
                mem_raddr = {addr_q[31:2], 2'b00};
                if (wen_q) begin
                    case (size_q)
                        2'b00:   mem_wmask = {4'h0, 4'b0001 << addr_q[1:0]};
                        2'b01:   mem_wmask = {4'h0, 4'b0011 << addr_q[1:0]};
                        default: mem_wmask = 8'h0F;
                    endcase
                    mem_din = wdata_q << {addr_q[1:0], 3'b000};
                end
                state_nxt = wen_q ? RESP : WAIT_R;
            end
            WAIT_R: begin
                if (mem_ready || timed_out) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (fire_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid & err_q;

    // Request latch and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (fire_req) begin
                wen_q   <= req_wen;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= 32'h0;
                err_q   <= req_bad;
            end else if (state == WAIT_R) begin
                if (mem_ready) begin
                    rdata_q <= load_data;
                    err_q   <= 1'b0;
                end else if (timed_out) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed bench for ysyx_24080014_lsu. Inputs change and outputs are sampled 1ns after posedge.
module tb_ysyx_24080014_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_wen, mem_ren, mem_ready;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_waddr, mem_raddr, mem_din, mem_dout;

    int checks   = 0;
    int failures = 0;

    ysyx_24080014_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_wmask(mem_wmask), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_din(mem_din), .mem_ready(mem_ready), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for a single accept edge. The LSU is then in REQ, or in RESP on error.
    task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF;
    endtask

    logic [31:0] held;
    int          n;

    initial begin
        rst = 1'b1; req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 1; mem_ready = 0; mem_dout = 0;
        tick(); tick();
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_wmask", {24'h0, mem_wmask}, 32'h0);
        rst = 1'b0;
        tick();

        // Store a byte to lane 3.
        issue(1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h0000_00AB);
        chk("sb_mem_valid", {29'h0, mem_valid, mem_wen, mem_ren}, 32'h6);
        chk("sb_wmask", {24'h0, mem_wmask}, 32'h08);
        chk("sb_din", mem_din, 32'hAB00_0000);
        chk("sb_waddr", mem_waddr, 32'h8000_0000);
        chk("sb_raddr", mem_raddr, 32'h8000_0000);
        chk("sb_req_ready", {31'h0, req_ready}, 32'h0);
        tick();
        chk("sb_resp", {30'h0, resp_valid, resp_err}, 32'h2);
        chk("sb_rdata", resp_rdata, 32'h0);
        chk("sb_mem_idle", {31'h0, mem_valid}, 32'h0);
        tick();
        chk("sb_back_idle", {30'h0, req_ready, resp_valid}, 32'h2);

        // Store a half to lane 2 and a word.
        issue(1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h0000_BEEF);
        chk("sh_wmask", {24'h0, mem_wmask}, 32'h0C);
        chk("sh_din", mem_din, 32'hBEEF_0000);
        tick(); tick();
        issue(1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'h1122_3344);
        chk("sw_wmask", {24'h0, mem_wmask}, 32'h0F);
        chk("sw_din", mem_din, 32'h1122_3344);
        chk("sw_waddr", mem_waddr, 32'h8000_0004);
        tick(); tick();

        // Signed half load. A mem_ready pulse during REQ must be ignored.
        issue(1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0);
        chk("lh_req", {29'h0, mem_valid, mem_wen, mem_ren}, 32'h5);
        chk("lh_raddr", mem_raddr, 32'h8000_0000);
        chk("lh_wmask", {24'h0, mem_wmask}, 32'h0);
        mem_ready = 1'b1; mem_dout = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        chk("lh_early_ready_ignored", {30'h0, resp_valid, mem_valid}, 32'h0);
        tick();
        mem_ready = 1'b1; mem_dout = 32'h8001_1234;
        tick();
        mem_ready = 1'b0;
        chk("lh_signed_rdata", resp_rdata, 32'hFFFF_8001);
        chk("lh_signed_err", {30'h0, resp_valid, resp_err}, 32'h2);
        tick();

        // Unsigned half load. mem_ready arrives in the first WAIT_R cycle.
        issue(1'b0, 2'b01, 1'b1, 32'h8000_0002, 32'h0);
        tick();
        mem_ready = 1'b1; mem_dout = 32'h8001_1234;
        tick();
        mem_ready = 1'b0;
        chk("lhu_rdata", resp_rdata, 32'h0000_8001);
        tick();

        // Signed byte load from lane 0, then a word load.
        issue(1'b0, 2'b00, 1'b0, 32'h8000_0000, 32'h0);
        tick();
        mem_ready = 1'b1; mem_dout = 32'h1234_5680;
        tick();
        mem_ready = 1'b0;
        chk("lb_signed_rdata", resp_rdata, 32'hFFFF_FF80);
        tick();
        issue(1'b0, 2'b10, 1'b0, 32'h8000_0008, 32'h0);
        tick();
        mem_ready = 1'b1; mem_dout = 32'hCAFE_F00D;
        tick();
        mem_ready = 1'b0;
        chk("lw_rdata", resp_rdata, 32'hCAFE_F00D);
        tick();

        // A misaligned word load and an illegal size never touch memory.
        issue(1'b0, 2'b10, 1'b0, 32'h8000_0006, 32'h0);
        chk("mis_no_mem", {31'h0, mem_valid}, 32'h0);
        chk("mis_resp", {30'h0, resp_valid, resp_err}, 32'h3);
        chk("mis_rdata", resp_rdata, 32'h0);
        tick();
        issue(1'b1, 2'b11, 1'b0, 32'h8000_0000, 32'h55);
        chk("illegal_resp", {29'h0, mem_valid, resp_valid, resp_err}, 32'h3);
        tick();

        // Unsigned byte load held while resp_ready is low.
        resp_ready = 1'b0;
        issue(1'b0, 2'b00, 1'b1, 32'h8000_0001, 32'h0);
        tick();
        mem_ready = 1'b1; mem_dout = 32'h1234_F678;
        tick();
        mem_ready = 1'b0;
        held = resp_rdata;
        chk("lbu_rdata", held, 32'h0000_00F6);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {resp_rdata[31:2], resp_valid, req_ready},
                {held[31:2], 1'b1, 1'b0});
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("stall_release", {30'h0, req_ready, resp_valid}, 32'h2);

        // Reset while in WAIT_R drops the load. A late mem_ready must not produce a response.
        issue(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wait_state", {29'h0, req_ready, mem_valid, resp_valid}, 32'h4);
        mem_ready = 1'b1; mem_dout = 32'h1111_1111;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("rst_wait_no_resp", {30'h0, req_ready, resp_valid}, 32'h2);

        // Load with no memory reply.
        issue(1'b0, 2'b10, 1'b0, 32'h8000_0020, 32'h0);
        tick();
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
        chk("timeout_cycles", n, 32'd16);
        chk("timeout_err", {30'h0, resp_valid, resp_err}, 32'h3);
        chk("timeout_rdata", resp_rdata, 32'h0);
        tick();
        mem_ready = 1'b1; mem_dout = 32'h2222_2222;
        tick();
        mem_ready = 1'b0;
        chk("timeout_late_ready", {30'h0, req_ready, resp_valid}, 32'h2);
`else
        chk("no_timeout_still_waiting", {30'h0, resp_valid, req_ready}, 32'h0);
        mem_ready = 1'b1; mem_dout = 32'h2222_2222;
        tick();
        mem_ready = 1'b0;
        chk("late_ready_resp", {30'h0, resp_valid, resp_err}, 32'h2);
        chk("late_ready_rdata", resp_rdata, 32'h2222_2222);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
